// File: rtl/core_alu_issue.sv
// Issue/writeback stage in front of core_alu: an EX slot that feeds the ALU and
// a WB slot that offers the registered result to the register-file write port.
module core_alu_issue #(
  parameter int W    = 16,
  parameter int REGS = 16,
  localparam int RW  = $clog2(REGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [2:0]    in_op_i,
  input  logic [RW-1:0] in_rd_i,
  input  logic [RW-1:0] in_rn_i,
  input  logic [RW-1:0] in_rm_i,
  input  logic          in_use_imm_i,
  input  logic [W-1:0]  in_imm_i,
  output logic [RW-1:0] rf_idx_a_o,
  output logic [RW-1:0] rf_idx_b_o,
  input  logic [W-1:0]  rf_data_a_i,
  input  logic [W-1:0]  rf_data_b_i,
  output logic [2:0]    alu_op_o,
  output logic [W-1:0]  alu_a_o,
  output logic [W-1:0]  alu_b_o,
  input  logic [W-1:0]  alu_q_i,
  output logic          wb_valid_o,
  input  logic          wb_ready_i,
  output logic [RW-1:0] wb_rd_o,
  output logic [W-1:0]  wb_data_o,
  output logic          illegal_o,
  output logic          busy_o
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_EOR = 3'd3;
  localparam logic [2:0] ALU_ORR = 3'd4;

  logic          ex_valid_q, ex_valid_d;
  logic [2:0]    ex_op_q, ex_op_d;
  logic [RW-1:0] ex_rd_q, ex_rd_d;
  logic [RW-1:0] ex_rn_q, ex_rn_d;
  logic [RW-1:0] ex_rm_q, ex_rm_d;
  logic          ex_use_imm_q, ex_use_imm_d;
  logic [W-1:0]  ex_imm_q, ex_imm_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [W-1:0]  wb_data_q, wb_data_d;
  logic          illegal_q, illegal_d;
  logic          busy_q, busy_d;

  logic adv, ex_retire, op_legal, accept;

  assign adv        = !wb_valid_q || wb_ready_i;
  assign in_ready_o = !rst_i && (!ex_valid_q || adv);

  always_comb begin
    ex_retire = ex_valid_q && adv && !flush_i;
    op_legal  = (ex_op_q == ALU_ADD) || (ex_op_q == ALU_SUB) || (ex_op_q == ALU_AND) ||
                (ex_op_q == ALU_EOR) || (ex_op_q == ALU_ORR);
    // An offer coinciding with a flush is dropped even if in_ready was high.
    accept    = in_valid_i && in_ready_o && !flush_i;

    ex_valid_d   = ex_valid_q;
    ex_op_d      = ex_op_q;
    ex_rd_d      = ex_rd_q;
    ex_rn_d      = ex_rn_q;
    ex_rm_d      = ex_rm_q;
    ex_use_imm_d = ex_use_imm_q;
    ex_imm_d     = ex_imm_q;
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    illegal_d    = ex_retire && !op_legal;

    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_op_d      = in_op_i;
      ex_rd_d      = in_rd_i;
      ex_rn_d      = in_rn_i;
      ex_rm_d      = in_rm_i;
      ex_use_imm_d = in_use_imm_i;
      ex_imm_d     = in_imm_i;
    end else if (ex_retire) begin
      ex_valid_d = 1'b0;
    end

    if (ex_retire && op_legal) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = ex_rd_q;
      wb_data_d  = alu_q_i;
    end else if (wb_valid_q && wb_ready_i) begin
      wb_valid_d = 1'b0;
    end

    busy_d = ex_valid_d || wb_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q   <= 1'b0;
      ex_op_q      <= ALU_ADD;
      ex_rd_q      <= '0;
      ex_rn_q      <= '0;
      ex_rm_q      <= '0;
      ex_use_imm_q <= 1'b0;
      ex_imm_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      illegal_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_rd_q      <= ex_rd_d;
      ex_rn_q      <= ex_rn_d;
      ex_rm_q      <= ex_rm_d;
      ex_use_imm_q <= ex_use_imm_d;
      ex_imm_q     <= ex_imm_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      illegal_q    <= illegal_d;
      busy_q       <= busy_d;
    end
  end

  // WB result is forwarded into EX even while it is being written this cycle.
  always_comb begin
    rf_idx_a_o = ex_rn_q;
    rf_idx_b_o = ex_rm_q;
    alu_op_o   = ex_op_q;
    alu_a_o    = (wb_valid_q && (wb_rd_q == ex_rn_q)) ? wb_data_q : rf_data_a_i;
    if (ex_use_imm_q) begin
      alu_b_o = ex_imm_q;
    end else if (wb_valid_q && (wb_rd_q == ex_rm_q)) begin
      alu_b_o = wb_data_q;
    end else begin
      alu_b_o = rf_data_b_i;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign illegal_o  = illegal_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/core_alu_issue.md
# core_alu_issue

Issue/writeback stage that drives `core_alu`. It accepts one decoded ALU instruction per cycle from decode, reads operands from the register file, and presents `op/a/b` to the ALU. It registers the result and offers it to the register-file write port through a valid/ready handshake. It provides a two-slot pipeline (EX, WB), forwards the WB result into EX, flags illegal ALU op encodings, and supports a flush from the branch unit.

## Interface
- `W`, 16: datapath width; must match `core_alu`.
- `REGS`, 16: architectural register count; `RW = $clog2(REGS)`.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard the EX slot this edge; WB is unaffected.
- `in_valid`  in  1  decoded ALU instruction present.
- `in_ready`  out  1  stage accepts; transfer when `in_valid && in_ready` at an edge.
- `in_op`  in  alu_op  operation; legal encodings are `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_EOR`, `ALU_ORR`.
- `in_rd`, `in_rn`, `in_rm`  in  RW  destination and source register indices.
- `in_use_imm`  in  1  b operand is `in_imm` instead of `rm`.
- `in_imm`  in  W  immediate, already extended by decode.
- `rf_idx_a`, `rf_idx_b`  out  RW  register-file read addresses (= EX `rn`, `rm`).
- `rf_data_a`, `rf_data_b`  in  W  combinational read data for those addresses.
- `alu_op`  out  alu_op  to `core_alu.op`.
- `alu_a`, `alu_b`  out  W  to `core_alu.a/b`.
- `alu_q`  in  W  from `core_alu.q`.
- `wb_valid`  out  1  result pending for the register file.
- `wb_ready`  in  1  write port grants; write occurs at that edge.
- `wb_rd`  out  RW  destination index.
- `wb_data`  out  W  result.
- `illegal`  out  1  one-cycle pulse: EX held an illegal op and retired.
- `busy`  out  1  EX or WB slot occupied.

## Operation
- State = {EX slot valid, WB slot valid}:
  - EMPTY (0,0), EX (1,0), WB (0,1), FULL (1,1).
  - EX holds `op, rd, rn, rm, use_imm, imm`.
  - WB holds `rd, data`.
- Advance condition: `adv = !wb_valid || wb_ready`.
  - EX retires at an edge when EX is valid and `adv`.
  - `in_ready = !rst && (!ex_valid || adv)`.
- Operand selection in EX:
  - a = `wb_data` if `wb_valid && wb_rd == rn`, else `rf_data_a`.
  - b = `imm` if `use_imm`; else `wb_data` if `wb_valid && wb_rd == rm`; else `rf_data_b`.
  - Forwarding applies even in a cycle where WB is being written (`wb_ready` = 1).
- `alu_op` = EX op. Outputs are driven from EX regardless of EX valid; consumers qualify them.
- Legal op retire: WB ← {`rd`, `alu_q`}, `wb_valid` = 1.
- Illegal op retire (any encoding outside the five legal ops):
  - no WB load;
  - `illegal` = 1 for the following cycle;
  - WB drains normally if `wb_ready`.
- WB clears when `wb_ready` is high and no new legal retire occurs at the same edge. Retire and drain at the same edge leave WB loaded with the new result.
- `flush` at an edge:
  - EX becomes invalid; no retire from EX, no `illegal` pulse;
  - an instruction offered at that same edge is not accepted (`in_ready` is ignored);
  - WB and the handshake with the register file continue.
- Arithmetic: W-bit modulo; carry/borrow discarded.
- Reset outputs: `in_ready` = 0 while `rst`, `wb_valid` = 0, `illegal` = 0, `busy` = 0. WB `rd`/`data` are cleared to 0.
- `rst` mid-operation discards both slots with no writeback. `in_ready` = 1 in the first cycle after `rst` falls.

## Timing
- Accept at edge k. The ALU evaluates during cycle k..k+1. Result is in WB (`wb_valid` = 1) after edge k+1. With `wb_ready` held high, the register file is written at edge k+2.
- Throughput: 1 instruction/cycle while `wb_ready` = 1.
- Backpressure:
  - `wb_ready` = 0 with FULL gives `in_ready` = 0 combinationally in the same cycle;
  - no instruction is dropped or duplicated.
- Back-to-back dependent instructions (rd of i = rn/rm of i+1) need no stall, via forwarding.
- `illegal` is high exactly the cycle after the retire edge.
- `busy` is registered: the OR of the slot valids.

## Test plan
- Reset, then `ADD r1 ← r2(3) + imm 4`, `wb_ready` = 1 → `wb_valid` 2 edges after accept, `wb_rd` = 1, `wb_data` = 7; `busy` drops 1 cycle later.
- `SUB r3 ← r4(0x0000) − r5(0x0001)` → `wb_data` = 0xFFFF; `ADD` of 0xFFFF + 0x0002 → 0x0001.
- Dependent stream: `ADD r1 ← r0(5) + imm 1`, then `EOR r2 ← r1 ^ imm 0x00FF` on consecutive cycles; regfile still holds stale r1 = 0 → `wb_data` = 0x00F9, `in_ready` never low.
- Hold `wb_ready` = 0 for 3 cycles with 3 instructions offered: `in_ready` = 0 once FULL; after release, all results are written in order with correct values, none lost.
- Illegal op encoding followed by `ORR 0x0F00 | 0x00F0`: `illegal` pulses 1 cycle with no WB; the next result is 0x0FF0.
- `flush` the cycle an instruction sits in EX while WB holds a result: the flushed instruction never appears on `wb_*`, the WB result still writes, and assert `rst` mid-stream → all outputs at reset values the next cycle.
